// File: rtl/vx_launch_ctrl.sv
// vx_launch_ctrl: kernel-launch sequencer between host control and the Vortex
// core wrapper. Host DCR writes are buffered while idle; a start replays them
// to the core DCR port, holds core reset for RESET_DELAY cycles, releases it
// and waits for the kernel to finish (busy falls) or be declared empty.
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   cfg_valid/cfg_ready        host DCR write handshake (cfg_addr, cfg_data)
//   start, abort               launch request (level) / cancel launch
//   vx_reset                   reset to the core wrapper
//   dcr_wr_valid/addr/data     DCR write strobe towards the core
//   vx_busy                    core busy
//   running, done, done_status sequencer status (0 ok, 1 empty, 2 aborted)
//   cfg_overflow               sticky push-while-full flag, cleared on start
//   run_cycles                 saturating count of cycles spent in RUN
module vx_launch_ctrl #(
  parameter int unsigned DCR_ADDR_WIDTH = 12,
  parameter int unsigned DCR_DATA_WIDTH = 32,
  parameter int unsigned DCR_DEPTH      = 8,
  parameter int unsigned RESET_DELAY    = 16,
  parameter int unsigned BUSY_WAIT      = 64,
  parameter int unsigned CYCLE_WIDTH    = 48
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      cfg_valid,
  output logic                      cfg_ready,
  input  logic [DCR_ADDR_WIDTH-1:0] cfg_addr,
  input  logic [DCR_DATA_WIDTH-1:0] cfg_data,
  input  logic                      start,
  input  logic                      abort,
  output logic                      vx_reset,
  output logic                      dcr_wr_valid,
  output logic [DCR_ADDR_WIDTH-1:0] dcr_wr_addr,
  output logic [DCR_DATA_WIDTH-1:0] dcr_wr_data,
  input  logic                      vx_busy,
  output logic                      running,
  output logic                      done,
  output logic [1:0]                done_status,
  output logic                      cfg_overflow,
  output logic [CYCLE_WIDTH-1:0]    run_cycles
);

  localparam int unsigned PW = $clog2(DCR_DEPTH);
  localparam int unsigned HW = $clog2(RESET_DELAY + 1);
  localparam int unsigned WW = $clog2(BUSY_WAIT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DCR,
    S_HOLD,
    S_RUN,
    S_DONE
  } state_t;

  state_t state;

  logic [DCR_ADDR_WIDTH-1:0] addr_mem [DCR_DEPTH];
  logic [DCR_DATA_WIDTH-1:0] data_mem [DCR_DEPTH];
  logic [PW-1:0]             wr_ptr;
  logic [PW-1:0]             rd_ptr;
  logic [PW:0]               count;
  logic                      full;
  logic                      push;
  logic [HW-1:0]             hold_cnt;
  logic [WW-1:0]             wait_cnt;
  logic                      seen_busy;
  logic                      seen_now;

  // cfg_ready and running are pure decodes of registered state.
  assign full      = (count == (PW+1)'(DCR_DEPTH));
  assign cfg_ready = (state == S_IDLE) && !full;
  assign running   = (state != S_IDLE);
  assign push      = cfg_valid && cfg_ready;
  assign seen_now  = seen_busy || vx_busy;

  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr] <= cfg_addr;
      data_mem[wr_ptr] <= cfg_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      hold_cnt     <= '0;
      wait_cnt     <= '0;
      seen_busy    <= 1'b0;
      vx_reset     <= 1'b1;
      dcr_wr_valid <= 1'b0;
      dcr_wr_addr  <= '0;
      dcr_wr_data  <= '0;
      done         <= 1'b0;
      done_status  <= 2'd0;
      cfg_overflow <= 1'b0;
      run_cycles   <= '0;
    end else begin
      done         <= 1'b0;
      dcr_wr_valid <= 1'b0;
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      // Abort in DCR/HOLD/RUN takes priority over every other transition
      // and drops whatever is still buffered.
      if (abort && (state == S_DCR || state == S_HOLD || state == S_RUN)) begin
        state       <= S_DONE;
        done        <= 1'b1;
        done_status <= 2'd2;
        vx_reset    <= 1'b1;
        count       <= '0;
        rd_ptr      <= wr_ptr;
        if (state == S_RUN && run_cycles != '1) begin
          run_cycles <= run_cycles + 1'b1;
        end
      end else begin
        case (state)
          S_IDLE: begin
            vx_reset <= 1'b1;
            if (push) begin
              count <= count + 1'b1;
            end
            if (cfg_valid && full) begin
              cfg_overflow <= 1'b1;
            end
            if (start) begin
              state        <= S_DCR;
              run_cycles   <= '0;
              done_status  <= 2'd0;
              cfg_overflow <= 1'b0;
            end
          end
          S_DCR: begin
            if (count != '0) begin
              dcr_wr_valid <= 1'b1;
              dcr_wr_addr  <= addr_mem[rd_ptr];
              dcr_wr_data  <= data_mem[rd_ptr];
              rd_ptr       <= rd_ptr + 1'b1;
              count        <= count - 1'b1;
            end else begin
              state    <= S_HOLD;
              hold_cnt <= HW'(RESET_DELAY - 1);
            end
          end
          S_HOLD: begin
            if (hold_cnt == '0) begin
              state     <= S_RUN;
              vx_reset  <= 1'b0;
              seen_busy <= 1'b0;
              wait_cnt  <= '0;
            end else begin
              hold_cnt <= hold_cnt - 1'b1;
            end
          end
          S_RUN: begin
            if (run_cycles != '1) begin
              run_cycles <= run_cycles + 1'b1;
            end
            seen_busy <= seen_now;
            if (seen_busy && !vx_busy) begin
              state       <= S_DONE;
              done        <= 1'b1;
              done_status <= 2'd0;
              vx_reset    <= 1'b1;
            end else if (!seen_now && wait_cnt == WW'(BUSY_WAIT - 1)) begin
              state       <= S_DONE;
              done        <= 1'b1;
              done_status <= 2'd1;
              vx_reset    <= 1'b1;
            end else if (!seen_now) begin
              wait_cnt <= wait_cnt + 1'b1;
            end
          end
          S_DONE: begin
            state <= S_IDLE;
          end
          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule
